// File: rtl/feature_loader.sv
// Streams one log-mel spectrogram (frame-major, bin-minor) into one of two
// ping-pong feature banks, quantising each IN_W sample to signed DATA_W with
// round-half-up and saturation. Write address comes from a running counter.
module feature_loader #(
  parameter int unsigned N_FRAMES = 49,
  parameter int unsigned N_BINS   = 40,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              buf_sel_i,
  input  logic              abort_i,
  input  logic [3:0]        quant_shift_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [IN_W-1:0]   s_data_i,
  input  logic              s_last_i,
  output logic              a_we_o,
  output logic [ADDR_W-1:0] a_waddr_o,
  output logic [DATA_W-1:0] a_wdata_o,
  output logic              b_we_o,
  output logic [ADDR_W-1:0] b_waddr_o,
  output logic [DATA_W-1:0] b_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned BinW   = (N_BINS > 1) ? $clog2(N_BINS) : 1;
  localparam int unsigned FrameW = (N_FRAMES > 1) ? $clog2(N_FRAMES + 1) : 1;

  localparam logic [BinW-1:0]   LastBin   = BinW'(N_BINS - 1);
  localparam logic [FrameW-1:0] LastFrame = FrameW'(N_FRAMES - 1);

  // Saturation bounds expressed at the widened sum width.
  localparam logic signed [IN_W:0] SatMax = (IN_W + 1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [IN_W:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [BinW-1:0]     bin_q, bin_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sel_q, sel_d;
  logic [3:0]          shift_q, shift_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                xfer;
  logic                last_bin;
  logic                last_frame;
  logic signed [IN_W:0] q_round;
  logic signed [IN_W:0] q_sum;
  logic signed [IN_W:0] q_shr;
  logic [DATA_W-1:0]   q_data;

  assign s_ready_o  = (state_q == StLoad);
  assign xfer       = s_ready_o && s_valid_i;
  assign last_bin   = (bin_q == LastBin);
  assign last_frame = (frame_q == LastFrame);

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign err_o     = err_q;
  // Both banks share the registered address/data; only the enables are steered.
  assign a_we_o    = we_q & ~sel_q;
  assign b_we_o    = we_q & sel_q;
  assign a_waddr_o = waddr_q;
  assign b_waddr_o = waddr_q;
  assign a_wdata_o = wdata_q;
  assign b_wdata_o = wdata_q;

  // Quantise the incoming sample: round-half-up, arithmetic shift, saturate.
  always_comb begin
    q_round = '0;
    if (shift_q != 4'd0) begin
      q_round = (IN_W + 1)'(1) << (shift_q - 4'd1);
    end
    // One extra bit of headroom so the rounding add never overflows.
    q_sum = $signed({s_data_i[IN_W-1], s_data_i}) + q_round;
    q_shr = q_sum >>> shift_q;
    if (q_shr > SatMax) begin
      q_data = SatMax[DATA_W-1:0];
    end else if (q_shr < SatMin) begin
      q_data = SatMin[DATA_W-1:0];
    end else begin
      q_data = q_shr[DATA_W-1:0];
    end
  end

  // Next-state: FSM, counters, latched config and the registered write port.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    frame_d = frame_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sel_d   = buf_sel_i;
          shift_d = quant_shift_i;
          bin_d   = '0;
          frame_d = '0;
          addr_d  = '0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = q_data;
          addr_d  = addr_q + ADDR_W'(1);
          // s_last only checks framing; it never steers the counters.
          if (s_last_i != last_bin) begin
            err_d = 1'b1;
          end
          if (last_bin) begin
            bin_d   = '0;
            frame_d = frame_q + FrameW'(1);
          end else begin
            bin_d = bin_q + BinW'(1);
          end
        end
        // Abort wins over completion; a same-cycle write still goes out.
        if (abort_i) begin
          state_d = StIdle;
        end else if (xfer && last_bin && last_frame) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      frame_q <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      shift_q <= 4'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_feature_loader.sv
// Self-checking bench for feature_loader: quantisation table, full and
// back-pressured loads against an arithmetic reference, framing error,
// abort, ignored start and asynchronous reset.
module tb_feature_loader;

  localparam int NF    = 49;
  localparam int NB    = 40;
  localparam int IN_W  = 16;
  localparam int DW    = 8;
  localparam int AW    = 14;
  localparam int Total = NF * NB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i, buf_sel_i, abort_i;
  logic [3:0]      quant_shift_i;
  logic            s_valid_i, s_ready_o, s_last_i;
  logic [IN_W-1:0] s_data_i;
  logic            a_we_o, b_we_o;
  logic [AW-1:0]   a_waddr_o, b_waddr_o;
  logic [DW-1:0]   a_wdata_o, b_wdata_o;
  logic            busy_o, done_o, err_o;

  feature_loader #(
    .N_FRAMES(NF), .N_BINS(NB), .IN_W(IN_W), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .buf_sel_i    (buf_sel_i),
    .abort_i      (abort_i),
    .quant_shift_i(quant_shift_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .s_last_i     (s_last_i),
    .a_we_o       (a_we_o),
    .a_waddr_o    (a_waddr_o),
    .a_wdata_o    (a_wdata_o),
    .b_we_o       (b_we_o),
    .b_waddr_o    (b_waddr_o),
    .b_wdata_o    (b_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pcyc  = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct {int bank; int addr; int data; int cyc;} wr_t;
  typedef struct {int cyc; int err;} dn_t;
  typedef struct {int shift; int x; int y;} qvec_t;

  wr_t  wq[$];
  dn_t  done_q[$];
  int   err_rise_q[$];
  logic err_prev = 1'b0;

  // Observer: log every bank write, done pulse and err rise, away from the edge.
  always @(negedge clk) begin
    if (a_we_o) wq.push_back('{0, int'(a_waddr_o), int'(a_wdata_o), pcyc});
    if (b_we_o) wq.push_back('{1, int'(b_waddr_o), int'(b_wdata_o), pcyc});
    if (done_o) done_q.push_back('{pcyc, int'(err_o)});
    if (err_o && !err_prev) err_rise_q.push_back(pcyc);
    err_prev <= err_o;
  end

  int exp_q[$];
  int wbase, dbase, ebase;
  int last_dec, bad_dec;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference quantiser: round half up, floor-divide by 2^s, clamp to int8.
  function automatic int quant(input int x, input int s);
    int y;
    y = x + ((s > 0) ? (1 << (s - 1)) : 0);
    y = y >>> s;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  function automatic int sample(input int mode, input int i);
    if (mode == 0) return 256 * ((i % 256) - 128);
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_load(input int sel, input int shift, input int mode, input int gap_pct,
                          input int bad_idx, input int abort_after, input int glitch_at);
    int sent, budget, x;
    exp_q.delete();
    last_dec = -1;
    bad_dec  = -1;
    x        = 0;
    @(negedge clk);
    wbase = wq.size();
    dbase = done_q.size();
    ebase = err_rise_q.size();
    start_i       = 1'b1;
    buf_sel_i     = sel[0];
    quant_shift_i = shift[3:0];
    @(negedge clk);
    start_i = 1'b0;
    check("err_cleared_on_start", err_o, 0);
    sent   = 0;
    budget = 0;
    while (sent < Total && budget < 20000) begin
      start_i = 1'b0;
      abort_i = 1'b0;
      if (sent == abort_after) begin
        s_valid_i = 1'b0;
        abort_i   = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        break;
      end
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        s_valid_i = 1'b0;
      end else begin
        x         = sample(mode, sent);
        s_valid_i = 1'b1;
        s_data_i  = x[IN_W-1:0];
        s_last_i  = ((sent % NB) == NB - 1) != (sent == bad_idx);
        if (sent == glitch_at) begin
          start_i       = 1'b1;
          buf_sel_i     = ~sel[0];
          quant_shift_i = shift[3:0] ^ 4'd5;
        end
      end
      if (s_valid_i && s_ready_o) begin
        exp_q.push_back(quant(x, shift));
        last_dec = pcyc;
        if (sent == bad_idx) bad_dec = pcyc;
        sent++;
      end
      @(negedge clk);
      budget++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    if (budget >= 20000) check("load_timeout_transfers", sent, Total);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_run(input string name, input int sel, input int n_exp, input int n_done,
                           input int exp_err);
    int nw, nd, bad;
    nw  = wq.size() - wbase;
    nd  = done_q.size() - dbase;
    bad = 0;
    check({name, "_write_count"}, nw, n_exp);
    check({name, "_model_count"}, exp_q.size(), n_exp);
    for (int i = 0; i < nw; i++) begin
      if (i >= exp_q.size() || wq[wbase+i].bank != sel || wq[wbase+i].addr != i ||
          wq[wbase+i].data != (exp_q[i] & 255)) begin
        if (bad == 0)
          $display("first bad write %0d: bank %0d addr %0d data %0d", i, wq[wbase+i].bank,
                   wq[wbase+i].addr, wq[wbase+i].data);
        bad++;
      end
    end
    check({name, "_bad_writes"}, bad, 0);
    check({name, "_done_pulses"}, nd, n_done);
    if (n_done > 0 && nd > 0 && nw > 0) begin
      check({name, "_done_cycle_vs_xfer"}, done_q[dbase].cyc, last_dec + 1);
      check({name, "_done_cycle_vs_last_write"}, done_q[dbase].cyc, wq[wbase+nw-1].cyc);
    end
    check({name, "_err"}, err_o, exp_err);
    check({name, "_busy_after"}, busy_o, 0);
  endtask

  qvec_t tbl[12];

  initial begin
    int n0;
    tbl[0]  = '{4, 32767, 8'h7F};
    tbl[1]  = '{4, -32768, 8'h80};
    tbl[2]  = '{4, 8, 1};
    tbl[3]  = '{4, 7, 0};
    tbl[4]  = '{4, -8, 0};
    tbl[5]  = '{0, -129, 8'h80};
    tbl[6]  = '{0, 127, 8'h7F};
    tbl[7]  = '{0, -128, 8'h80};
    tbl[8]  = '{1, 3, 2};
    tbl[9]  = '{1, -3, 8'hFF};
    tbl[10] = '{15, 32767, 1};
    tbl[11] = '{8, -32768, 8'h80};

    rst_n = 1'b0;
    start_i = 1'b0; buf_sel_i = 1'b0; abort_i = 1'b0; quant_shift_i = 4'd0;
    s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    #3;
    check("rst_ctrl", {s_ready_o, a_we_o, b_we_o, busy_o, done_o, err_o}, 0);
    check("rst_addr", {a_waddr_o, b_waddr_o}, 0);
    check("rst_data", {a_wdata_o, b_wdata_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Valid samples while idle are never accepted.
    n0 = wq.size();
    s_valid_i = 1'b1;
    s_data_i  = 16'h1234;
    repeat (3) @(negedge clk);
    check("idle_ready", s_ready_o, 0);
    s_valid_i = 1'b0;
    @(negedge clk);
    check("idle_no_writes", wq.size() - n0, 0);

    // Quantisation table: one transfer with a same-cycle abort per vector.
    foreach (tbl[i]) begin
      int xv;
      xv = tbl[i].x;
      @(negedge clk);
      start_i = 1'b1; buf_sel_i = 1'b0; quant_shift_i = tbl[i].shift[3:0];
      @(negedge clk);
      start_i = 1'b0; s_valid_i = 1'b1; s_data_i = xv[IN_W-1:0]; s_last_i = 1'b0;
      abort_i = 1'b1;
      @(negedge clk);
      s_valid_i = 1'b0; abort_i = 1'b0;
      check($sformatf("quant_s%0d_x%0d", tbl[i].shift, tbl[i].x), a_wdata_o, tbl[i].y);
      check($sformatf("quant_we_%0d", i), {a_we_o, b_we_o}, 2'b10);
      check($sformatf("quant_addr_%0d", i), a_waddr_o, 0);
      @(negedge clk);
      check($sformatf("quant_idle_%0d", i), busy_o, 0);
    end

    run_load(0, 8, 0, 0, -1, -1, -1);
    check_run("full", 0, Total, 1, 0);

    run_load(1, int'($urandom_range(0, 15)), 1, 40, -1, -1, -1);
    check_run("backpressure", 1, Total, 1, 0);

    run_load(0, 6, 1, 15, 3 * NB + 38, -1, -1);
    check_run("framing", 0, Total, 1, 1);
    check("framing_err_rises", err_rise_q.size() - ebase, 1);
    if (err_rise_q.size() > ebase) check("framing_err_cycle", err_rise_q[ebase], bad_dec + 1);
    if (done_q.size() > dbase) check("framing_err_at_done", done_q[dbase].err, 1);

    run_load(0, 8, 0, 20, -1, 100, -1);
    check_run("abort", 0, 100, 0, 0);

    run_load(0, 8, 1, 10, -1, -1, 50);
    check_run("ignored_start", 0, Total, 1, 0);

    // Asynchronous reset mid-load with bank B actively writing.
    @(negedge clk);
    dbase = done_q.size();
    start_i = 1'b1; buf_sel_i = 1'b1; quant_shift_i = 4'd0;
    @(negedge clk);
    start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 16'd100; s_last_i = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("pre_reset_b_we", {a_we_o, b_we_o, busy_o}, 3'b011);
    check("pre_reset_b_wdata", b_wdata_o, 100);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {s_ready_o, a_we_o, b_we_o, busy_o, done_o, err_o}, 0);
    check("async_rst_addr", {a_waddr_o, b_waddr_o}, 0);
    check("async_rst_data", {a_wdata_o, b_wdata_o}, 0);
    s_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("async_rst_no_done", done_q.size() - dbase, 0);
    check("async_rst_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/feature_loader.md
FEATURE_LOADER -- requirements
Module: feature_loader

Interface
REQ-001 SHALL have parameter N_FRAMES, default 49, mel frames per input (feature-map rows).
REQ-002 SHALL have parameter N_BINS, default 40, mel bins per frame (feature-map columns).
REQ-003 SHALL have parameters IN_W (default 16, signed log-mel sample width), DATA_W (default 8, INT8 output width) and ADDR_W (default 14, bank address width).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock; port rst_n, input, 1, asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin loading one spectrogram.
REQ-006 buf_sel  input  1  ping-pong select, sampled on accepted start; 0 targets bank A, 1 targets bank B.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 quant_shift  input  4  right-shift amount, IN_W to INT8 quantisation; sampled on accepted start.
REQ-009 s_valid / s_ready / s_data[IN_W-1:0] / s_last  in/out/in/in  stream handshake for samples, frame-major, bin-minor; s_last marks the last bin of a frame.
REQ-010 a_we, a_waddr[ADDR_W-1:0], a_wdata[DATA_W-1:0]  output  bank A write port.
REQ-011 b_we, b_waddr[ADDR_W-1:0], b_wdata[DATA_W-1:0]  output  bank B write port.
REQ-012 busy  output  1  high from accepted start until return to IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 err  output  1  sticky framing error.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-016 IDLE: s_ready=0; start=1 latches buf_sel and quant_shift, clears the bin, frame and address counters and err, and moves to LOAD.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 LOAD: s_ready=1; a transfer occurs when s_valid and s_ready are both high.
REQ-019 Each transfer SHALL produce exactly one write, registered, on the cycle after the transfer: selected-bank we=1, waddr=frame*N_BINS+bin, wdata=quantised sample.
REQ-020 The write address SHALL come from a running counter, with no multiplier; the first write goes to address 0 and the last to N_FRAMES*N_BINS-1 (1959).
REQ-021 The non-selected bank SHALL have we=0 at all times; waddr and wdata are don't-care when we=0.
REQ-022 Quantisation, with s = quant_shift: y = (x + (s>0 ? 2^(s-1) : 0)) >>> s, arithmetic, with the addition done at IN_W+1 bits so it cannot overflow.
REQ-023 Quantisation result y SHALL saturate to [-128, 127].
REQ-024 The bin counter SHALL wrap N_BINS-1 -> 0 and increment the frame counter.
REQ-025 Addressing SHALL use only the internal counters; s_last SHALL NOT affect addressing.
REQ-026 s_last mismatch: if s_last != (bin == N_BINS-1) on a transfer, err SHALL set and stay set until the next accepted start or reset.
REQ-027 The transfer with frame = N_FRAMES-1 and bin = N_BINS-1 SHALL move the FSM to DONE; s_ready SHALL be 0 from the following cycle.
REQ-028 DONE lasts exactly one cycle: the final write is present, done=1, busy=1; the FSM then goes to IDLE.
REQ-029 abort=1 in LOAD SHALL return the FSM to IDLE next cycle, with no done pulse and err unchanged.
REQ-030 On abort, a write registered from a same-cycle transfer SHALL still be issued; no further writes follow.
REQ-031 abort SHALL be ignored in IDLE and DONE.
REQ-032 s_valid while IDLE SHALL produce no transfer and no write.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, all counters 0, s_ready=0, a_we=b_we=0, a_waddr=b_waddr=0, a_wdata=b_wdata=0, busy=0, done=0, err=0, latched buf_sel=0, latched quant_shift=0.
REQ-034 Reset during LOAD SHALL abandon the load; data already written stays in the bank, and no done pulse is generated.

Verification
REQ-035 Full load: buf_sel=0, shift=8, stream 1960 samples with x=256*k (k=-128..127, cycled) and correct s_last -> a_waddr 0..1959 in order, a_wdata = k, b_we never high, done pulses once on the cycle of the write to address 1959, err=0.
REQ-036 Quantisation edges: shift=4, x=32767 -> 0x7F; x=-32768 -> 0x80; x=8 -> 1 (rounded up); x=7 -> 0; x=-8 -> 0; shift=0, x=-129 -> 0x80.
REQ-037 Backpressure: random s_valid gaps, buf_sel=1 -> writes only on b_*, contiguous addresses, total write count = 1960, completion cycle = last transfer + 1.
REQ-038 Framing: s_last asserted at bin 38 of frame 3 -> err=1 from the next cycle; addresses unaffected; err held through done and cleared on next start.
REQ-039 Abort/reset: abort after 100 transfers -> exactly 100 writes, done never pulses, next start restarts at address 0.
REQ-040 Reset: rst_n low mid-LOAD -> all outputs at reset values with no clock edge.
REQ-041 Ignored start: start pulsed during LOAD -> no effect on counters or latched buf_sel.
